// File: rtl/initialize_remote_pkg.sv
// Shared types and default throttle codes for the remote arming sequencer.
package initialize_remote_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW1,
    HIGH,
    LOW2,
    DONE,
    RAMP_UP,
    RAMP_DOWN
  } state_e;

  localparam logic [7:0] LOW_VAL     = 8'h00;
  localparam logic [7:0] HIGH_VAL    = 8'hFF;
  localparam logic [7:0] NEUTRAL_VAL = 8'h80;
  localparam logic [7:0] OFF_VAL     = 8'h00;

endpackage

// File: rtl/initialize_remote_sync_2ff.sv
// 1-bit two-flop synchronizer with a rising-edge pulse on the synchronized level.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       q_dly_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      q_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      q_dly_q <= sync_q[1];
    end
  end

  assign q_o    = sync_q[1];
  // Flops reset to 0, so a switch already on at reset release still yields a rise.
  assign rise_o = sync_q[1] & ~q_dly_q;

endmodule

// File: rtl/initialize_remote.sv
// Remote arming sequencer: OFF -> LOW -> HIGH -> LOW -> NEUTRAL on power-switch rise.
// Optional INIT_RAMP_EN macro replaces the step transitions with 1-LSB ramps.
module initialize_remote #(
`ifdef INIT_RAMP_EN
  parameter int unsigned RAMP_DIV    = 1,
`endif
  parameter int unsigned STEP_CYCLES = 100,
  parameter logic [7:0]  LOW_VAL     = initialize_remote_pkg::LOW_VAL,
  parameter logic [7:0]  HIGH_VAL    = initialize_remote_pkg::HIGH_VAL,
  parameter logic [7:0]  NEUTRAL_VAL = initialize_remote_pkg::NEUTRAL_VAL,
  parameter logic [7:0]  OFF_VAL     = initialize_remote_pkg::OFF_VAL
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       on_state,
  output logic [7:0] initial_signal,
  output logic       init_done
);

  import initialize_remote_pkg::*;

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);

  logic       on_s;
  logic       rise;
  state_e     state_q;
  logic [15:0] cnt_q;
  logic [7:0] out_q;
  logic       done_q;
  logic       step_done;

  sync_2ff u_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (on_state),
    .q_o    (on_s),
    .rise_o (rise)
  );

  assign step_done = (cnt_q == STEP_LAST);

`ifdef INIT_RAMP_EN
  localparam logic [15:0] RAMP_LAST = 16'(RAMP_DIV - 1);

  state_e     ramp_next_q;
  logic [7:0] ramp_tgt_q;
  logic [7:0] ramp_val;

  assign ramp_val = (state_q == RAMP_UP) ? out_q + 8'd1 : out_q - 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= OFF_VAL;
      done_q      <= 1'b0;
      ramp_next_q <= IDLE;
      ramp_tgt_q  <= '0;
    end else if (state_q != IDLE && !on_s) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= OFF_VAL;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= LOW1;
            cnt_q   <= '0;
            out_q   <= LOW_VAL;
          end
        end
        LOW1, HIGH, LOW2: begin
          if (step_done) begin
            cnt_q <= '0;
            // Ramp direction is fixed per hold phase; output holds its level on entry.
            case (state_q)
              LOW1: begin
                state_q     <= RAMP_UP;
                ramp_tgt_q  <= HIGH_VAL;
                ramp_next_q <= HIGH;
              end
              HIGH: begin
                state_q     <= RAMP_DOWN;
                ramp_tgt_q  <= LOW_VAL;
                ramp_next_q <= LOW2;
              end
              default: begin
                state_q     <= RAMP_UP;
                ramp_tgt_q  <= NEUTRAL_VAL;
                ramp_next_q <= DONE;
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (cnt_q == RAMP_LAST) begin
            cnt_q <= '0;
            if (out_q == ramp_tgt_q) begin
              state_q <= ramp_next_q;
              done_q  <= (ramp_next_q == DONE);
            end else begin
              out_q <= ramp_val;
              if (ramp_val == ramp_tgt_q) begin
                state_q <= ramp_next_q;
                done_q  <= (ramp_next_q == DONE);
              end
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          out_q   <= OFF_VAL;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= OFF_VAL;
      done_q  <= 1'b0;
    end else if (state_q != IDLE && !on_s) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= OFF_VAL;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= LOW1;
            cnt_q   <= '0;
            out_q   <= LOW_VAL;
          end
        end
        LOW1: begin
          if (step_done) begin
            state_q <= HIGH;
            cnt_q   <= '0;
            out_q   <= HIGH_VAL;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        HIGH: begin
          if (step_done) begin
            state_q <= LOW2;
            cnt_q   <= '0;
            out_q   <= LOW_VAL;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        LOW2: begin
          if (step_done) begin
            state_q <= DONE;
            cnt_q   <= '0;
            out_q   <= NEUTRAL_VAL;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          out_q   <= OFF_VAL;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign initial_signal = out_q;
  assign init_done      = done_q;

endmodule

// File: tb/tb_initialize_remote.sv
// Randomized bench for initialize_remote against a timeline-based reference model.
module tb_initialize_remote;

  localparam int unsigned STEP = 100;

  logic       clock;
  logic       reset_n;
  logic       on_state;
  logic [7:0] initial_signal;
  logic       init_done;

  int total = 0;
  int bad   = 0;

  // Reference: switch level delayed through two flops, then elapsed time since start.
  logic m_s1, m_s2, m_s2d;
  logic m_active;
  int   m_t;

  initialize_remote #(
    .STEP_CYCLES (STEP),
    .LOW_VAL     (8'h00),
    .HIGH_VAL    (8'hFF),
    .NEUTRAL_VAL (8'h80),
    .OFF_VAL     (8'h00)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .on_state       (on_state),
    .initial_signal (initial_signal),
    .init_done      (init_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [7:0] exp_out();
    if (!m_active)         return 8'h00;
    if (m_t < STEP)        return 8'h00;
    if (m_t < 2 * STEP)    return 8'hFF;
    if (m_t < 3 * STEP)    return 8'h00;
    return 8'h80;
  endfunction

  function automatic logic exp_done();
    return m_active && (m_t >= 3 * STEP);
  endfunction

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_s2d = 1'b0;
    m_active = 1'b0; m_t = 0;
  endtask

  task automatic model_edge();
    logic rise;
    if (!reset_n) begin
      model_reset();
      return;
    end
    rise = m_s2 & ~m_s2d;
    if (!m_active) begin
      if (rise) begin
        m_active = 1'b1;
        m_t = 0;
      end
    end else if (!m_s2) begin
      m_active = 1'b0;
    end else if (m_t < 3 * STEP) begin
      m_t++;
    end
    m_s2d = m_s2;
    m_s2  = m_s1;
    m_s1  = on_state;
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk8("signal", initial_signal, exp_out());
    chk1("done", init_done, exp_done());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    reset_n  = 1'b0;
    on_state = 1'b0;
    model_reset();
    #1;
    chk8("reset_signal", initial_signal, 8'h00);
    chk1("reset_done", init_done, 1'b0);

    ticks(10);
    reset_n = 1'b1;
    ticks(5);

    // Full sequence: first HIGH code appears 3 + STEP edges after the raise.
    on_state = 1'b1;
    n = 0;
    while (n < 200 && initial_signal !== 8'hFF) begin
      tick();
      n++;
    end
    chki("latency_to_high", n, 3 + STEP);
    n = 0;
    while (n < 300 && init_done !== 1'b1) begin
      tick();
      n++;
    end
    chki("high_plus_low2_len", n, 2 * STEP);
    chk8("done_code", initial_signal, 8'h80);
    ticks(400);
    chk8("no_restart", initial_signal, 8'h80);

    // Abort during HIGH, then restart after a pause.
    on_state = 1'b0;
    ticks($urandom_range(40, 60));
    on_state = 1'b1;
    ticks(3 + STEP + $urandom_range(1, 90));
    chk8("in_high", initial_signal, 8'hFF);
    on_state = 1'b0;
    ticks(3);
    chk8("abort_signal", initial_signal, 8'h00);
    chk1("abort_done", init_done, 1'b0);
    ticks(50);
    on_state = 1'b1;
    ticks(3 + 2 * STEP + $urandom_range(5, 90));

    // Asynchronous reset in the middle of LOW2.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk8("async_rst_signal", initial_signal, 8'h00);
    chk1("async_rst_done", init_done, 1'b0);
    ticks(3);
    reset_n = 1'b1;
    ticks(3 * STEP + 10);
    chk1("restart_done", init_done, 1'b1);

    // Short pulses: one-cycle switch activity must enter LOW1 and then abort.
    for (int k = 0; k < 4; k++) begin
      on_state = 1'b0;
      ticks(4);
      on_state = 1'b1;
      ticks($urandom_range(1, 3));
    end

    // Random on/off episodes.
    for (int k = 0; k < 8; k++) begin
      on_state = 1'($urandom_range(0, 1));
      ticks($urandom_range(1, 420));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
